ped_phase_ctrl: RTL and testbench
=================================

# ped_phase_ctrl

Phase scheduler for the pedestrian crossing. It owns the car and pedestrian light sequence, latches push-button requests and times every phase from a 1 Hz tick. It drives the walk-phase countdown counter through `cnt_change` and `cnt_pause`. It sits between the board inputs (button, pause switch, tick divider) and the counter/display datapath.

## Interface
- `GREEN_MIN`, 10: minimum car-green duration in ticks (1..15).
- `YELLOW_T`, 3: car-yellow duration in ticks (1..15).
- `ALLRED_T`, 1: all-red clearance duration in ticks, used on both sides of the pedestrian phase (1..15).
- `WALK_T`, 10: solid-walk duration in ticks (1..15).
- `FLASH_T`, 5: flashing-walk duration in ticks (1..15).

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `tick`  in  1: one-`clk`-wide 1 Hz strobe.
- `ped_btn`  in  1: raw pedestrian button, asynchronous, active-high.
- `pause_sw`  in  1: raw pause switch, asynchronous, level.
- `car_r`, `car_y`, `car_g`  out  1 each: car lights, one-hot.
- `ped_walk`  out  1: pedestrian walk lamp.
- `ped_stop`  out  1: pedestrian stop lamp.
- `ped_pending`  out  1: a request is latched and not yet served.
- `remain`  out  4: ticks left in the current phase.
- `cnt_change`  out  1: one-cycle pulse to the counter's `change_state`.
- `cnt_pause`  out  1: synchronized pause level to the counter's `pause`.

## Operation
- Synchronizers: `ped_btn` and `pause_sw` each pass through two flops. A button request is the rising edge of the synchronized button, detected with a third flop.
- Request latch:
  - A request edge sets `ped_pending` in states GREEN, YELLOW and RED1.
  - A request edge is dropped in WALK, FLASH and RED2.
  - `ped_pending` clears on entry to WALK.
- Pause:
  - `cnt_pause` equals the synchronized `pause_sw`.
  - While it is 1, ticks are ignored, so state and `remain` freeze.
  - The request latch still operates during pause.
- States and the tick rule: GREEN, YELLOW, RED1, WALK, FLASH, RED2.
  - On state entry, `remain` loads that state's duration.
  - On an unpaused tick with `remain`>1, `remain` decrements by 1.
  - On an unpaused tick with `remain`==1, the state transitions, so each phase lasts exactly its duration in ticks.
- Transitions:
  - GREEN: while `remain`==1, hold if `ped_pending`==0. On a tick with `ped_pending`==1, go to YELLOW.
  - YELLOW → RED1 → WALK → FLASH → RED2 → GREEN.
- Outputs per state:
  - GREEN: `car_g`=1. YELLOW: `car_y`=1. All other states: `car_r`=1.
  - WALK: `ped_walk`=1, `ped_stop`=0.
  - FLASH: `ped_stop`=0; `ped_walk` starts at 1 on entry and toggles on every unpaused tick.
  - All other states: `ped_walk`=0, `ped_stop`=1.
- `cnt_change` pulses high for exactly one cycle on the cycle that enters WALK and on the cycle that enters RED2. It is never asserted otherwise.

## Timing
- Reset values:
  - state GREEN, `remain`=`GREEN_MIN`.
  - `car_g`=1, `car_r`=`car_y`=0.
  - `ped_stop`=1, `ped_walk`=0.
  - `ped_pending`=0, `cnt_change`=0, `cnt_pause`=0.
  - All synchronizer flops = 0.
- Reset asserted mid-phase returns to the reset values immediately (asynchronously); the latched request is lost.
- All outputs are registered. A state change and its lamp outputs become visible in the same cycle, one `clk` after the deciding tick edge.
- Button to `ped_pending`: 3 `clk` cycles after the raw rising edge (2 synchronizer stages plus the edge register).
- Pause latency: 2 `clk` cycles. A tick arriving in the same cycle that synchronized pause is 1 is ignored.
- Simultaneous events:
  - A request edge in the cycle WALK is entered is dropped; the clear wins.
  - A request edge on the GREEN→YELLOW tick is latched, with no effect on the current cycle.
- `remain` never reads 0 outside reset transients. A duration parameter of 0 is illegal.

## Test plan
- Reset and idle: release `rst`, apply 30 ticks with no request → GREEN held, `car_g`=1, `remain` counts 10..1 then holds at 1, `cnt_change` stays 0.
- Full cycle with default parameters: press at tick 2 → YELLOW after tick 10. Then RED1 for 3 ticks later, WALK for 1 tick later, FLASH for 10 ticks later, RED2 for 5 ticks later, GREEN after 1 more tick. `cnt_change` pulses exactly twice; `ped_pending` clears at WALK entry.
- Late request: press while GREEN with `remain`==1 → YELLOW on the next tick, not before.
- Pause in WALK at `remain`=6: hold `pause_sw` for 20 ticks → `remain` stays 6, `cnt_pause`=1, state stays WALK. After release, 6 more ticks are needed to reach FLASH.
- Dropped request: press during FLASH → `ped_pending` stays 0 and GREEN persists after RED2. Press during RED1 → `ped_pending`=1 and is served in the next cycle.
- Async reset mid-FLASH → `car_g`=1, `ped_stop`=1, `remain`=10 before the next `clk` edge.

Source files
------------

// File: rtl/ped_phase_ctrl.sv
// ped_phase_ctrl: pedestrian crossing phase scheduler with request latch, pause and per-phase tick timing
module ped_phase_ctrl #(
  parameter int GREEN_MIN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 10,
  parameter int FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_btn,
  input  logic       pause_sw,
  output logic       car_r,
  output logic       car_y,
  output logic       car_g,
  output logic       ped_walk,
  output logic       ped_stop,
  output logic       ped_pending,
  output logic [3:0] remain,
  output logic       cnt_change,
  output logic       cnt_pause
);
  typedef enum logic [2:0] {GREEN, YELLOW, RED1, WALK, FLASH, RED2} state_t;
  state_t state, nxt;
  logic btn_s1, btn_s2, btn_d, pause_s1;
  logic req, step, adv;
  function automatic logic [3:0] dur(state_t s);
    return s == GREEN  ? 4'(GREEN_MIN) :
           s == YELLOW ? 4'(YELLOW_T)  :
           s == WALK   ? 4'(WALK_T)    :
           s == FLASH  ? 4'(FLASH_T)   : 4'(ALLRED_T);
  endfunction
  assign req  = btn_s2 & ~btn_d;
  assign step = tick & ~cnt_pause;
  // GREEN only leaves once its minimum has run out and a request is waiting
  assign adv  = step && remain == 4'd1 && (state != GREEN || ped_pending);
  always_comb
    nxt = !adv            ? state  :
          state == GREEN  ? YELLOW :
          state == YELLOW ? RED1   :
          state == RED1   ? WALK   :
          state == WALK   ? FLASH  :
          state == FLASH  ? RED2   : GREEN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_d       <= 1'b0;
      pause_s1    <= 1'b0;
      cnt_pause   <= 1'b0;
      state       <= GREEN;
      remain      <= 4'(GREEN_MIN);
      ped_pending <= 1'b0;
      car_r       <= 1'b0;
      car_y       <= 1'b0;
      car_g       <= 1'b1;
      ped_walk    <= 1'b0;
      ped_stop    <= 1'b1;
      cnt_change  <= 1'b0;
    end else begin
      btn_s1      <= ped_btn;
      btn_s2      <= btn_s1;
      btn_d       <= btn_s2;
      pause_s1    <= pause_sw;
      cnt_pause   <= pause_s1;
      state       <= nxt;
      remain      <= adv ? dur(nxt) : (step && remain > 4'd1) ? remain - 4'd1 : remain;
      // entering WALK serves the request, so it beats a same-cycle edge
      ped_pending <= (adv && nxt == WALK) ? 1'b0 :
                     (req && state inside {GREEN, YELLOW, RED1}) ? 1'b1 : ped_pending;
      car_g       <= nxt == GREEN;
      car_y       <= nxt == YELLOW;
      car_r       <= !(nxt == GREEN || nxt == YELLOW);
      ped_walk    <= nxt == WALK || (nxt == FLASH && (adv ? 1'b1 : step ? ~ped_walk : ped_walk));
      ped_stop    <= !(nxt == WALK || nxt == FLASH);
      cnt_change  <= adv && (nxt == WALK || nxt == RED2);
    end
endmodule

// File: tb/tb_ped_phase_ctrl.sv
// tb_ped_phase_ctrl: random stimulus against a phase-table reference model
module tb_ped_phase_ctrl;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, ped_btn = 1'b0, pause_sw = 1'b0;
  logic car_r, car_y, car_g, ped_walk, ped_stop, ped_pending, cnt_change, cnt_pause;
  logic [3:0] remain;
  int checks = 0, errors = 0;
  int dur[6] = '{10, 3, 1, 10, 5, 1};
  int p, left, walks;
  bit pend, fw, chg;
  bit bh[$], ph[$];
  always #5 clk = ~clk;
  ped_phase_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_btn(ped_btn), .pause_sw(pause_sw),
    .car_r(car_r), .car_y(car_y), .car_g(car_g), .ped_walk(ped_walk), .ped_stop(ped_stop),
    .ped_pending(ped_pending), .remain(remain), .cnt_change(cnt_change), .cnt_pause(cnt_pause)
  );
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    p = 0; left = dur[0]; pend = 0; fw = 0; chg = 0;
    bh = '{0, 0, 0, 0};
    ph = '{0, 0, 0, 0};
  endtask
  // phase = index into the duration table; button/pause history models the input delays
  task automatic model_edge(bit tk, bit b, bit ps);
    int old_p;
    bit t, r, enter_walk;
    bh.push_front(b); void'(bh.pop_back());
    ph.push_front(ps); void'(ph.pop_back());
    old_p = p; chg = 0; enter_walk = 0;
    t = tk && !ph[2];
    r = bh[2] && !bh[3];
    if (t) begin
      if (left > 1) begin
        left--;
        if (p == 4) fw = !fw;
      end else if (p != 0 || pend) begin
        p = (p + 1) % 6;
        left = dur[p];
        fw = 1;
        chg = p == 3 || p == 5;
        enter_walk = p == 3;
        if (enter_walk) walks++;
      end
    end
    if (enter_walk) pend = 0;
    else if (r && old_p <= 2) pend = 1;
  endtask
  task automatic check_all();
    chk("lamps", 32'({car_r, car_y, car_g, ped_walk, ped_stop}),
        32'({p > 1, p == 1, p == 0, p == 3 || (p == 4 && fw), !(p == 3 || p == 4)}));
    chk("remain", 32'(remain), 32'(left));
    chk("pending", 32'(ped_pending), 32'(pend));
    chk("cnt_change", 32'(cnt_change), 32'(chg));
    chk("cnt_pause", 32'(cnt_pause), 32'(ph[1]));
  endtask
  task automatic cyc(bit tk, bit b, bit ps);
    tick = tk; ped_btn = b; pause_sw = ps;
    @(posedge clk);
    model_edge(tk, b, ps);
    #1;
    check_all();
  endtask
  initial begin
    bit b, ps;
    int n;
    b = 0; ps = 0; walks = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) b = !b;
      ps = ps ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 149) == 0);
      cyc($urandom_range(0, 2) == 0, b, ps);
    end
    ps = 0; n = 0;
    while (p != 4 && n < 5000) begin
      cyc(n % 2 == 0, (n / 8) % 2 == 1, 1'b0);
      n++;
    end
    chk("reach_flash", 32'(p), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("async_car_g", 32'(car_g), 32'd1);
    chk("async_ped_stop", 32'(ped_stop), 32'd1);
    chk("async_remain", 32'(remain), 32'd10);
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    b = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) b = !b;
      ps = ps ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 149) == 0);
      cyc($urandom_range(0, 2) == 0, b, ps);
    end
    chk("walk_seen", 32'(walks > 1), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
